// File: rtl/logic_reduce_pipe_if.sv
// Handshake bundle for logic_reduce_pipe: input transaction channel, result
// channel and delivered-result counter.
interface logic_reduce_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [1:0]              in_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CNT_W-1:0]        out_count;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/logic_reduce_pipe.sv
// Two-stage handshaked bitwise reduction (AND/OR/XOR/NAND) across NUM_IN lanes,
// with synchronous flush and a wrapping delivered-result counter.
module logic_reduce_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  logic_reduce_pipe_if.slave bus
);

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;

  logic [NUM_IN*WIDTH-1:0] r_data_p1;
  logic [1:0]              r_mode_p1;
  logic                    r_vld_p1;
  logic [WIDTH-1:0]        r_data_p2;
  logic                    r_vld_p2;
  logic [CNT_W-1:0]        r_count_p2;

  logic             w_s2_free;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_advance;
  logic             w_deliver;
  logic [WIDTH-1:0] w_result;

  function automatic logic [WIDTH-1:0] f_reduce(
    input logic [NUM_IN*WIDTH-1:0] d,
    input logic [1:0]              m
  );
    logic [WIDTH-1:0] a, o, x;
    a = d[WIDTH-1:0];
    o = d[WIDTH-1:0];
    x = d[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      a = a & d[k*WIDTH +: WIDTH];
      o = o | d[k*WIDTH +: WIDTH];
      x = x ^ d[k*WIDTH +: WIDTH];
    end
    case (m)
      MODE_AND: f_reduce = a;
      MODE_OR:  f_reduce = o;
      MODE_XOR: f_reduce = x;
      default:  f_reduce = ~a;
    endcase
  endfunction

  // in_ready depends only on clear, out_ready and registered state, never in_valid
  assign w_s2_free  = !r_vld_p2 | bus.out_ready;
  assign w_in_ready = !clear & (!r_vld_p1 | w_s2_free);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_advance  = r_vld_p1 & w_s2_free;
  assign w_deliver  = r_vld_p2 & bus.out_ready;
  assign w_result   = f_reduce(r_data_p1, r_mode_p1);

  // Stage 1: operand and mode capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_mode_p1 <= '0;
    end else if (clear) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_mode_p1 <= '0;
    end else if (w_accept) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= bus.in_data;
      r_mode_p1 <= bus.in_mode;
    end else if (w_advance) begin
      r_vld_p1  <= 1'b0;
    end
  end

  // Stage 2: registered result and delivery count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p2   <= 1'b0;
      r_data_p2  <= '0;
      r_count_p2 <= '0;
    end else if (clear) begin
      r_vld_p2   <= 1'b0;
      r_data_p2  <= '0;
      r_count_p2 <= '0;
    end else begin
      if (w_advance) begin
        r_vld_p2  <= 1'b1;
        r_data_p2 <= w_result;
      end else if (w_deliver) begin
        r_vld_p2  <= 1'b0;
      end
      if (w_deliver) begin
        r_count_p2 <= r_count_p2 + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p2;
  assign bus.out_data  = r_data_p2;
  assign bus.out_count = r_count_p2;

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Directed self-checking bench for logic_reduce_pipe: a 2-lane/16-bit-count
// instance and a 4-lane/4-bit-count instance share clock and reset.
module tb_logic_reduce_pipe;

  logic clk;
  logic reset_n;
  logic clear0;
  logic clear1;
  int   errors;
  int   checks;

  logic_reduce_pipe_if #(.WIDTH(8), .NUM_IN(2), .CNT_W(16)) if0 ();
  logic_reduce_pipe_if #(.WIDTH(8), .NUM_IN(4), .CNT_W(4))  if1 ();

  logic_reduce_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear0), .bus(if0.slave)
  );
  logic_reduce_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clear1), .bus(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset_n = 1'b0;
    clear0 = 1'b0; clear1 = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = '0; if0.in_mode = 2'b00; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_mode = 2'b00; if1.out_ready = 1'b1;
    #3;
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid0 got=%b exp=0", if0.out_valid); end
    checks++; if (if0.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data0 got=%h exp=00", if0.out_data); end
    checks++; if (if0.out_count !== 16'd0) begin errors++; $display("FAIL reset_out_count0 got=%0d exp=0", if0.out_count); end
    checks++; if (if1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid1 got=%b exp=0", if1.out_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready0 got=%b exp=1", if0.in_ready); end
    checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready1 got=%b exp=1", if1.in_ready); end
  endtask

  task automatic test_basic_modes();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h30; exp_d[1] = 8'hFC; exp_d[2] = 8'hCC; exp_d[3] = 8'hCF;
    if0.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        if0.in_valid = 1'b1;
        if0.in_data  = {8'h3C, 8'hF0};
        if0.in_mode  = 2'(i);
      end else begin
        if0.in_valid = 1'b0;
      end
      #1;
      if (i < 4) begin
        checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready[%0d] got=%b exp=1", i, if0.in_ready); end
      end
      if (i >= 2 && i < 6) begin
        checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== exp_d[i-2])
          begin errors++; $display("FAIL basic_out[%0d] got=%b/%h exp=1/%h", i-2, if0.out_valid, if0.out_data, exp_d[i-2]); end
      end else begin
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle[%0d] got=%b exp=0", i, if0.out_valid); end
      end
      @(negedge clk);
    end
    checks++; if (if0.out_count !== 16'd4) begin errors++; $display("FAIL basic_count got=%0d exp=4", if0.out_count); end
  endtask

  task automatic test_multi_lane();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h0F; exp_d[1] = 8'hFF; exp_d[2] = 8'hD0; exp_d[3] = 8'hF0;
    if1.out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      if1.in_valid = 1'b1;
      if1.in_data  = {8'h1F, 8'h3F, 8'h0F, 8'hFF};
      if1.in_mode  = 2'(m);
      @(negedge clk);
      if1.in_valid = 1'b0;
      if1.in_mode  = 2'(3 - m);
      checks++; if (if1.out_valid !== 1'b0) begin errors++; $display("FAIL multi_lat1[%0d] got=%b exp=0", m, if1.out_valid); end
      @(negedge clk);
      checks++; if (if1.out_valid !== 1'b1 || if1.out_data !== exp_d[m])
        begin errors++; $display("FAIL multi_out[%0d] got=%b/%h exp=1/%h", m, if1.out_valid, if1.out_data, exp_d[m]); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_pressure();
    if0.out_ready = 1'b0;
    if0.in_mode   = 2'b01;
    if0.in_valid  = 1'b1;
    if0.in_data   = {8'h00, 8'h11};
    #1;
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a got=%b exp=1", if0.in_ready); end
    @(negedge clk);
    if0.in_data = {8'h00, 8'h22};
    #1;
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got=%b exp=1", if0.in_ready); end
    @(negedge clk);
    if0.in_data = {8'h00, 8'h33};
    #1;
    checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%b exp=0", if0.in_ready); end
    checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== 8'h11)
      begin errors++; $display("FAIL bp_head got=%b/%h exp=1/11", if0.out_valid, if0.out_data); end
    @(negedge clk);
    checks++; if (if0.in_ready !== 1'b0 || if0.out_data !== 8'h11)
      begin errors++; $display("FAIL bp_hold got=%b/%h exp=0/11", if0.in_ready, if0.out_data); end
    if0.out_ready = 1'b1;
    #1;
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", if0.in_ready); end
    @(negedge clk);
    if0.in_valid = 1'b0;
    checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== 8'h22)
      begin errors++; $display("FAIL bp_drain1 got=%b/%h exp=1/22", if0.out_valid, if0.out_data); end
    @(negedge clk);
    checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== 8'h33)
      begin errors++; $display("FAIL bp_drain2 got=%b/%h exp=1/33", if0.out_valid, if0.out_data); end
    @(negedge clk);
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", if0.out_valid); end
    checks++; if (if0.out_count !== 16'd7) begin errors++; $display("FAIL bp_count got=%0d exp=7", if0.out_count); end
  endtask

  task automatic test_flush();
    if0.out_ready = 1'b0;
    if0.in_mode   = 2'b01;
    if0.in_valid  = 1'b1;
    if0.in_data   = {8'h00, 8'h44};
    @(negedge clk);
    if0.in_data = {8'h00, 8'h55};
    @(negedge clk);
    if0.in_data = {8'h00, 8'h99};
    clear0 = 1'b1;
    #1;
    checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_during got=%b exp=0", if0.in_ready); end
    @(negedge clk);
    clear0 = 1'b0;
    if0.in_valid = 1'b0;
    #1;
    checks++; if (if0.out_valid !== 1'b0 || if0.out_data !== 8'h00)
      begin errors++; $display("FAIL flush_out got=%b/%h exp=0/00", if0.out_valid, if0.out_data); end
    checks++; if (if0.out_count !== 16'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", if0.out_count); end
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got=%b exp=1", if0.in_ready); end
    if0.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept[%0d] got=%b exp=0", i, if0.out_valid); end
    end
  endtask

  task automatic test_counter_wrap();
    clear1 = 1'b1;
    @(negedge clk);
    clear1 = 1'b0;
    if1.out_ready = 1'b1;
    if1.in_mode   = 2'b00;
    if1.in_data   = {8'hFF, 8'hFF, 8'hFF, 8'hA5};
    for (int i = 0; i < 20; i++) begin
      if1.in_valid = (i < 17);
      if (i == 17) begin
        checks++; if (if1.out_count !== 4'd15) begin errors++; $display("FAIL wrap_15 got=%0d exp=15", if1.out_count); end
      end
      if (i == 18) begin
        checks++; if (if1.out_count !== 4'd0) begin errors++; $display("FAIL wrap_16 got=%0d exp=0", if1.out_count); end
      end
      if (i == 19) begin
        checks++; if (if1.out_count !== 4'd1) begin errors++; $display("FAIL wrap_17 got=%0d exp=1", if1.out_count); end
      end
      @(negedge clk);
    end
    if1.in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    if0.out_ready = 1'b1;
    if0.in_mode   = 2'b01;
    if0.in_valid  = 1'b1;
    if0.in_data   = {8'h00, 8'h66};
    @(negedge clk);
    if0.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if0.out_ready = 1'b0;
    if0.in_valid  = 1'b1;
    if0.in_data   = {8'h00, 8'h77};
    @(negedge clk);
    if0.in_data = {8'h00, 8'h88};
    @(negedge clk);
    if0.in_valid = 1'b0;
    checks++; if (if0.out_valid !== 1'b1 || if0.out_count !== 16'd1 || if0.in_ready !== 1'b0)
      begin errors++; $display("FAIL ar_pre got=%b/%0d/%b exp=1/1/0", if0.out_valid, if0.out_count, if0.in_ready); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (if0.out_valid !== 1'b0 || if0.out_data !== 8'h00 || if0.out_count !== 16'd0)
      begin errors++; $display("FAIL ar_immediate got=%b/%h/%0d exp=0/00/0", if0.out_valid, if0.out_data, if0.out_count); end
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1)
      begin errors++; $display("FAIL ar_released got=%b/%b exp=0/1", if0.out_valid, if0.in_ready); end
    if0.out_ready = 1'b1;
    if0.in_mode   = 2'b10;
    if0.in_valid  = 1'b1;
    if0.in_data   = {8'h0F, 8'hAA};
    @(negedge clk);
    if0.in_valid = 1'b0;
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL ar_lat1 got=%b exp=0", if0.out_valid); end
    @(negedge clk);
    checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== 8'hA5)
      begin errors++; $display("FAIL ar_lat2 got=%b/%h exp=1/a5", if0.out_valid, if0.out_data); end
    @(negedge clk);
    checks++; if (if0.out_count !== 16'd1) begin errors++; $display("FAIL ar_count got=%0d exp=1", if0.out_count); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_modes();
    test_multi_lane();
    test_back_pressure();
    test_flush();
    test_counter_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_reduce_pipe.md
# logic_reduce_pipe

Parametrised, handshaked, two-stage registered bitwise reduction unit. It combines NUM_IN input lanes of WIDTH bits with a per-transaction selectable operation (AND/OR/XOR/NAND). It also counts delivered results. It generalises the fixed 1-bit registered 2-input AND cell into a configurable datapath primitive for the example-design test suites, with back-pressure and synchronous flush.

## Interface
- WIDTH, 8, lane width in bits (>= 1)
- NUM_IN, 2, number of input lanes reduced together (>= 2)
- CNT_W, 16, width of the delivered-result counter

- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset; one clock domain (clk)
- clear  input  1  synchronous flush; active-high
- in_valid  input  1  upstream presents a transaction
- in_ready  output  1  block accepts the transaction this cycle
- in_data  input  NUM_IN*WIDTH  packed lanes; lane k = in_data[k*WIDTH +: WIDTH]
- in_mode  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_data  output  WIDTH  reduction result
- out_count  output  CNT_W  number of results delivered (out_valid & out_ready), wraps

## Operation
- **Stage 1 (capture):**
  - Registers in_data and in_mode when in_valid & in_ready.
  - Sets s1_valid.
- **Stage 2 (result):**
  - Computes the bitwise reduction across all NUM_IN lanes of the stage-1 operands, per stage-1 mode.
  - Registers it into out_data and sets out_valid.
  - NAND = bitwise inverse of the AND of all lanes.
- **Advance rules:**
  - s2_free = !out_valid | out_ready.
  - Stage 1 moves to stage 2 when s1_valid & s2_free.
  - in_ready = !clear & (!s1_valid | s2_free). This is combinational from out_ready and clear only, never from in_valid.
- **Hold:** while out_valid & !out_ready, out_data is held stable and stage 1 is held. No data is lost or duplicated.
- **out_count:**
  - Increments by 1 on each cycle with out_valid & out_ready.
  - Wraps from 2^CNT_W-1 to 0.
- **clear (synchronous):**
  - On the next edge, s1_valid and out_valid go to 0 and out_count goes to 0.
  - out_data and stage-1 registers are set to 0.
  - Nothing is accepted in a clear cycle, because in_ready = 0.
  - A delivery handshake in the same cycle is not counted; clear wins.
- **reset_n low (asynchronous):**
  - Immediately sets all state to 0: s1_valid=0, out_valid=0, out_data=0, out_count=0.
  - Any in-flight transaction is discarded.
  - After deassertion, in_ready = 1 (if clear low).
- Mode is carried with its data. Changing in_mode between transactions never affects transactions already accepted.

## Timing
- **Latency:** a transaction accepted at edge N drives out_valid=1 after edge N+1, provided stage 2 was free at edge N+1.
- **Throughput:** one transaction per cycle with out_ready held high.
- **Back-pressure:** with out_ready low, the block absorbs exactly 2 transactions (stage 1 + stage 2), then in_ready drops.
  - With out_valid high, in_ready rises in the same cycle out_ready rises.
- **Simultaneous events:** accept, advance and deliver may occur in one cycle. All state transitions use pre-edge values.
- **Reset values (all outputs):**
  - out_valid = 0, out_data = 0, out_count = 0.
  - in_ready = 1 while clear is low.
- reset_n deassertion is assumed synchronous to clk at system level. No internal synchroniser.

## Test plan
- **Basic modes:** WIDTH=8, NUM_IN=2, out_ready=1. Send lanes {0xF0,0x3C} with modes 00/01/10/11 on consecutive cycles.
  - Required: out_data = 0x30, 0xFC, 0xCC, 0xCF.
  - Each appears 2 cycles after acceptance, one per cycle.
  - out_count = 4.
- **Multi-lane:** NUM_IN=4, lanes {0xFF,0x0F,0x3F,0x1F}, mode AND.
  - Required: 0x0F.
  - Same lanes with mode XOR -> 0xD0.
- **Back-pressure:** out_ready=0, in_valid=1 continuously with distinct data.
  - Required: in_ready drops after 2 accepts, and out_data stays fixed.
  - Raise out_ready: results emerge in order, none lost or duplicated, one per cycle.
- **Counter wrap:** CNT_W=4. Deliver 17 results.
  - Required: out_count reads 15 after 15 deliveries, 0 after 16, 1 after 17.
- **Flush:** two transactions in flight with out_ready=0. Assert clear for 1 cycle while in_valid=1.
  - Required: next cycle out_valid=0, out_count=0, in_ready=1.
  - The input offered during clear is not accepted.
- **Async reset mid-stream:** pulse reset_n low between clock edges while out_valid=1 and s1 is full.
  - Required: out_valid, out_data and out_count go to 0 immediately, without a clock edge.
  - The first new transaction after release appears at latency 2.
